// File: rtl/dual_slope_ctrl.sv
// Dual-slope conversion sequencer: auto-zero, integrate and de-integrate phases.
// Each conversion is packed into a 32-bit result word and held on a valid/ready handshake.
module dual_slope_ctrl #(
  parameter int unsigned T_AZ        = 64,
  parameter int unsigned T_INT       = 1000,
  parameter int unsigned T_DEINT_MAX = 4095,
  parameter int unsigned UNDER_DIV   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        comp_i,
  input  logic        sat_hi_i,
  input  logic        sat_lo_i,
  input  logic        ref_ok_i,
  input  logic [1:0]  mode_sel_i,
  input  logic [2:0]  range_i,
  output logic [1:0]  afe_sel_o,
  output logic [2:0]  range_sel_o,
  output logic        afe_reset_o,
  output logic        ref_sign_o,
  output logic [31:0] result_o,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic        busy_o,
  output logic [3:0]  state_o
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] AZ_LAST   = CW'(T_AZ - 1);
  localparam logic [CW-1:0] INT_LAST  = CW'(T_INT - 1);
  localparam logic [CW-1:0] DEINT_MAX = CW'(T_DEINT_MAX);
  localparam logic [CW-1:0] UNDER_TH  = CW'(T_DEINT_MAX / UNDER_DIV);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_AZ       = 4'd1,
    S_INT      = 4'd2,
    S_SIGN     = 4'd3,
    S_DEINT    = 4'd4,
    S_DONE     = 4'd5,
    S_WAIT_ACK = 4'd6,
    S_HOLD     = 4'd7
  } state_t;

  state_t        r_state,     w_state_nxt;
  logic [CW-1:0] r_timer,     w_timer_nxt;
  logic [1:0]    r_mode,      w_mode_nxt;
  logic [2:0]    r_range_reg, w_range_reg_nxt;
  logic [2:0]    r_range_sel, w_range_sel_nxt;
  logic [1:0]    r_afe_sel,   w_afe_sel_nxt;
  logic          r_afe_reset, w_afe_reset_nxt;
  logic          r_pol,       w_pol_nxt;
  logic          r_ovr,       w_ovr_nxt;
  logic          r_sat,       w_sat_nxt;
  logic          r_rerr,      w_rerr_nxt;
  logic [CW-1:0] r_count,     w_count_nxt;
  logic [31:0]   r_result,    w_result_nxt;
  logic          r_valid,     w_valid_nxt;
  logic [7:0]    r_seq,       w_seq_nxt;
  logic          r_busy,      w_busy_nxt;
  logic          w_az_entry;
  logic [CW-1:0] w_timer_inc;

  assign w_timer_inc = r_timer + CW'(1);

  // Next-state, datapath and output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_mode_nxt      = r_mode;
    w_range_reg_nxt = r_range_reg;
    w_range_sel_nxt = r_range_sel;
    w_pol_nxt       = r_pol;
    w_ovr_nxt       = r_ovr;
    w_sat_nxt       = r_sat;
    w_rerr_nxt      = r_rerr;
    w_count_nxt     = r_count;
    w_result_nxt    = r_result;
    w_valid_nxt     = r_valid;
    w_seq_nxt       = r_seq;
    w_az_entry      = 1'b0;
    w_afe_sel_nxt   = 2'b00;
    w_afe_reset_nxt = 1'b1;
    w_busy_nxt      = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (mode_sel_i != 2'b00 && ref_ok_i) begin
          w_state_nxt = S_AZ;
          w_az_entry  = 1'b1;
        end
      end
      S_AZ, S_INT, S_SIGN, S_DEINT: begin
        if (mode_sel_i == 2'b00) begin
          w_state_nxt = S_IDLE;
        end else if (!ref_ok_i) begin
          w_state_nxt = S_DONE;
          w_ovr_nxt   = 1'b0;
          w_sat_nxt   = 1'b0;
          w_rerr_nxt  = 1'b1;
          w_count_nxt = '0;
        end else begin
          case (r_state)
            S_AZ: begin
              if (r_timer == AZ_LAST) begin
                w_state_nxt = S_INT;
                w_timer_nxt = '0;
              end else begin
                w_timer_nxt = w_timer_inc;
              end
            end
            S_INT: begin
              if (sat_hi_i || sat_lo_i) begin
                if (r_mode == 2'b11 && r_range_reg != 3'd7) begin
                  // Autorange: step to a less sensitive range and retry
                  w_range_reg_nxt = r_range_reg + 3'd1;
                  w_state_nxt     = S_AZ;
                  w_az_entry      = 1'b1;
                end else begin
                  w_state_nxt = S_DONE;
                  w_ovr_nxt   = 1'b0;
                  w_sat_nxt   = 1'b1;
                  w_rerr_nxt  = 1'b0;
                  w_count_nxt = '0;
                end
              end else if (r_timer == INT_LAST) begin
                w_state_nxt = S_SIGN;
              end else begin
                w_timer_nxt = w_timer_inc;
              end
            end
            S_SIGN: begin
              w_pol_nxt   = comp_i;
              w_state_nxt = S_DEINT;
              w_timer_nxt = '0;
            end
            default: begin
              // De-integrate until the comparator crosses back or the limit is hit
              if (comp_i != r_pol) begin
                w_state_nxt = S_DONE;
                w_ovr_nxt   = 1'b0;
                w_sat_nxt   = 1'b0;
                w_rerr_nxt  = 1'b0;
                w_count_nxt = r_timer;
              end else if (w_timer_inc == DEINT_MAX) begin
                w_state_nxt = S_DONE;
                w_ovr_nxt   = 1'b1;
                w_sat_nxt   = 1'b0;
                w_rerr_nxt  = 1'b0;
                w_count_nxt = DEINT_MAX;
              end else begin
                w_timer_nxt = w_timer_inc;
              end
            end
          endcase
        end
      end
      S_DONE: begin
        w_result_nxt = {r_ovr, r_sat, r_rerr, r_pol, r_range_sel, 1'b0, r_seq, r_count};
        w_valid_nxt  = 1'b1;
        w_state_nxt  = S_WAIT_ACK;
        if (r_mode == 2'b11 && !r_ovr && !r_sat && r_count < UNDER_TH && r_range_reg != 3'd0) begin
          w_range_reg_nxt = r_range_reg - 3'd1;
        end
      end
      S_WAIT_ACK: begin
        if (r_valid && result_ready_i) begin
          w_valid_nxt = 1'b0;
          w_seq_nxt   = r_seq + 8'd1;
          case (mode_sel_i)
            2'b00:   w_state_nxt = S_IDLE;
            2'b01:   w_state_nxt = S_HOLD;
            default: begin
              w_state_nxt = S_AZ;
              w_az_entry  = 1'b1;
            end
          endcase
        end
      end
      S_HOLD: begin
        if (mode_sel_i == 2'b00) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Conversion setup latched on every AZ entry
    if (w_az_entry) begin
      w_mode_nxt      = mode_sel_i;
      w_range_sel_nxt = (mode_sel_i == 2'b11) ? w_range_reg_nxt : range_i;
      w_timer_nxt     = '0;
      w_pol_nxt       = 1'b0;
    end

    case (w_state_nxt)
      S_INT: begin
        w_afe_sel_nxt   = 2'b01;
        w_afe_reset_nxt = 1'b0;
      end
      S_SIGN:  w_afe_reset_nxt = 1'b0;
      S_DEINT: begin
        w_afe_sel_nxt   = 2'b10;
        w_afe_reset_nxt = 1'b0;
      end
      default: w_afe_sel_nxt = 2'b00;
    endcase
    w_busy_nxt = !(w_state_nxt == S_IDLE || w_state_nxt == S_HOLD);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_mode      <= 2'b00;
      r_range_reg <= 3'd7;
      r_range_sel <= 3'd7;
      r_afe_sel   <= 2'b00;
      r_afe_reset <= 1'b1;
      r_pol       <= 1'b0;
      r_ovr       <= 1'b0;
      r_sat       <= 1'b0;
      r_rerr      <= 1'b0;
      r_count     <= '0;
      r_result    <= '0;
      r_valid     <= 1'b0;
      r_seq       <= 8'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_mode      <= w_mode_nxt;
      r_range_reg <= w_range_reg_nxt;
      r_range_sel <= w_range_sel_nxt;
      r_afe_sel   <= w_afe_sel_nxt;
      r_afe_reset <= w_afe_reset_nxt;
      r_pol       <= w_pol_nxt;
      r_ovr       <= w_ovr_nxt;
      r_sat       <= w_sat_nxt;
      r_rerr      <= w_rerr_nxt;
      r_count     <= w_count_nxt;
      r_result    <= w_result_nxt;
      r_valid     <= w_valid_nxt;
      r_seq       <= w_seq_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign afe_sel_o      = r_afe_sel;
  assign range_sel_o    = r_range_sel;
  assign afe_reset_o    = r_afe_reset;
  assign ref_sign_o     = r_pol;
  assign result_o       = r_result;
  assign result_valid_o = r_valid;
  assign busy_o         = r_busy;
  assign state_o        = 4'(r_state);

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed bench for dual_slope_ctrl: table of single conversions plus
// hand-written sequences for stall, autorange, abort and reset cases.
module tb_dual_slope_ctrl;

  localparam int T_AZ   = 64;
  localparam int T_INT  = 1000;
  localparam int NOFLIP = -1;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_AZ = 4'd1, ST_INT = 4'd2, ST_SIGN = 4'd3,
                         ST_DEINT = 4'd4, ST_DONE = 4'd5, ST_WAIT = 4'd6, ST_HOLD = 4'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        comp, sat_hi, sat_lo, ref_ok;
  logic [1:0]  mode_sel;
  logic [2:0]  range_in;
  logic [1:0]  afe_sel_o;
  logic [2:0]  range_sel_o;
  logic        afe_reset_o, ref_sign_o;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic        result_ready;
  logic        busy_o;
  logic [3:0]  state_o;

  int total = 0;
  int bad   = 0;

  dual_slope_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .comp_i         (comp),
    .sat_hi_i       (sat_hi),
    .sat_lo_i       (sat_lo),
    .ref_ok_i       (ref_ok),
    .mode_sel_i     (mode_sel),
    .range_i        (range_in),
    .afe_sel_o      (afe_sel_o),
    .range_sel_o    (range_sel_o),
    .afe_reset_o    (afe_reset_o),
    .ref_sign_o     (ref_sign_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready),
    .busy_o         (busy_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  rng;
    logic        pol;
    int          n;
    logic [31:0] exp_word;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [31:0] mk(input logic o, input logic s, input logic e, input logic p,
                                     input logic [2:0] r, input logic [7:0] q, input logic [15:0] c);
    return {o, s, e, p, r, 1'b0, q, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] st, input string name);
    int n = 0;
    while (state_o !== st && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(state_o), 32'(st));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (result_valid_o !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(result_valid_o), 1);
  endtask

  task automatic accept();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("valid_drop", 32'(result_valid_o), 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_afe_sel"},   32'(afe_sel_o),      0);
    check({tag, "_range_sel"}, 32'(range_sel_o),    7);
    check({tag, "_afe_reset"}, 32'(afe_reset_o),    1);
    check({tag, "_ref_sign"},  32'(ref_sign_o),     0);
    check({tag, "_result"},    result_o,            0);
    check({tag, "_valid"},     32'(result_valid_o), 0);
    check({tag, "_busy"},      32'(busy_o),         0);
    check({tag, "_state"},     32'(state_o),        32'(ST_IDLE));
  endtask

  // Runs one conversion up to result_valid; n = DEINT cycles before comp flips
  task automatic do_conv(input logic [1:0] m, input logic [2:0] r, input logic p, input int n);
    int k;
    mode_sel = m;
    range_in = r;
    comp     = p;
    ref_ok   = 1'b1;
    wait_state(ST_AZ, "reach_az");
    k = 0;
    while (state_o == ST_AZ && k < 5000) begin
      k++;
      @(negedge clk);
    end
    check("az_len", 32'(k), 32'(T_AZ));
    check("int_afe_sel", 32'(afe_sel_o), 1);
    check("int_afe_reset", 32'(afe_reset_o), 0);
    k = 0;
    while (state_o == ST_INT && k < 5000) begin
      k++;
      @(negedge clk);
    end
    check("int_len", 32'(k), 32'(T_INT));
    wait_state(ST_DEINT, "reach_deint");
    check("deint_afe_sel", 32'(afe_sel_o), 2);
    check("deint_ref_sign", 32'(ref_sign_o), 32'(p));
    if (n >= 0) begin
      repeat (n) @(negedge clk);
      comp = ~p;
    end
    wait_valid("conv_valid");
    comp = p;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ok;
    logic [2:0]  s2_rng[5];
    logic [2:0]  s2_nxt[5];
    int          s2_cnt[5];

    tbl[0] = '{mode: 2'b01, rng: 3'd2, pol: 1'b1, n: 300,    exp_word: 32'h1400_012C};
    tbl[1] = '{mode: 2'b01, rng: 3'd5, pol: 1'b0, n: 0,      exp_word: 32'h0A01_0000};
    tbl[2] = '{mode: 2'b01, rng: 3'd0, pol: 1'b1, n: 4094,   exp_word: 32'h1002_0FFE};
    tbl[3] = '{mode: 2'b01, rng: 3'd7, pol: 1'b1, n: NOFLIP, exp_word: 32'h9E03_0FFF};

    s2_rng = '{3'd7, 3'd6, 3'd6, 3'd5, 3'd4};
    s2_cnt = '{100, 255, 254, 0, 100};
    s2_nxt = '{3'd6, 3'd6, 3'd5, 3'd4, 3'd3};

    rst = 1'b1; comp = 1'b0; sat_hi = 1'b0; sat_lo = 1'b0; ref_ok = 1'b1;
    mode_sel = 2'b00; range_in = 3'd0; result_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single-mode conversions from the table
    foreach (tbl[i]) begin
      do_conv(tbl[i].mode, tbl[i].rng, tbl[i].pol, tbl[i].n);
      check($sformatf("tbl%0d_word", i), result_o, tbl[i].exp_word);
      check($sformatf("tbl%0d_range", i), 32'(range_sel_o), 32'(tbl[i].rng));
      repeat (3) @(negedge clk);
      check($sformatf("tbl%0d_held", i), result_o, tbl[i].exp_word);
      check($sformatf("tbl%0d_still_valid", i), 32'(result_valid_o), 1);
      accept();
      check($sformatf("tbl%0d_hold", i), 32'(state_o), 32'(ST_HOLD));
      check($sformatf("tbl%0d_hold_busy", i), 32'(busy_o), 0);
      mode_sel = 2'b00;
      @(negedge clk);
      check($sformatf("tbl%0d_idle", i), 32'(state_o), 32'(ST_IDLE));
    end

    // Continuous mode, overrange, consumer stalls for 50 cycles
    do_conv(2'b10, 3'd1, 1'b1, NOFLIP);
    check("cont_ovr_word", result_o, 32'h9204_0FFF);
    ok = 1'b1;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (result_o !== 32'h9204_0FFF || state_o !== ST_WAIT || result_valid_o !== 1'b1) ok = 1'b0;
    end
    check("stall_stable", 32'(ok), 1);
    accept();
    check("cont_restart_az", 32'(state_o), 32'(ST_AZ));
    do_conv(2'b10, 3'd1, 1'b1, 10);
    check("cont_second_word", result_o, 32'h1205_000A);
    mode_sel = 2'b00;
    repeat (2) @(negedge clk);
    check("pending_kept", 32'(result_valid_o), 1);
    accept();
    check("cont_to_idle", 32'(state_o), 32'(ST_IDLE));

    // Reference lost during de-integrate
    mode_sel = 2'b01; range_in = 3'd3; comp = 1'b1;
    wait_state(ST_DEINT, "ref_reach_deint");
    repeat (20) @(negedge clk);
    ref_ok = 1'b0;
    wait_valid("ref_valid");
    ref_ok = 1'b1;
    check("ref_err_word", result_o, 32'h3606_0000);
    accept();
    check("ref_hold", 32'(state_o), 32'(ST_HOLD));
    mode_sel = 2'b00;
    @(negedge clk);

    // Idle request mid-integrate
    mode_sel = 2'b01; range_in = 3'd0;
    wait_state(ST_INT, "abort_reach_int");
    repeat (5) @(negedge clk);
    mode_sel = 2'b00;
    @(negedge clk);
    check("abort_state", 32'(state_o), 32'(ST_IDLE));
    check("abort_busy", 32'(busy_o), 0);
    check("abort_afe_reset", 32'(afe_reset_o), 1);
    ok = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (result_valid_o !== 1'b0) ok = 1'b0;
    end
    check("abort_no_valid", 32'(ok), 1);

    // Reset mid-DEINT
    mode_sel = 2'b10; range_in = 3'd4; comp = 1'b1;
    wait_state(ST_DEINT, "rst_reach_deint");
    repeat (50) @(negedge clk);
    rst = 1'b1;
    mode_sel = 2'b00;
    @(negedge clk);
    reset_checks("midrst");
    rst = 1'b0;
    @(negedge clk);

    // Autorange from reset: underrange steps down, count 255 does not
    for (int k = 0; k < 5; k++) begin
      do_conv(2'b11, 3'd0, 1'b1, s2_cnt[k]);
      check($sformatf("auto%0d_word", k), result_o,
            mk(1'b0, 1'b0, 1'b0, 1'b1, s2_rng[k], 8'(k), 16'(s2_cnt[k])));
      accept();
      check($sformatf("auto%0d_az", k), 32'(state_o), 32'(ST_AZ));
      check($sformatf("auto%0d_next_range", k), 32'(range_sel_o), 32'(s2_nxt[k]));
    end

    // Saturation in INT cycle 10 walks the range up to 7
    for (int r = 3; r < 7; r++) begin
      wait_state(ST_INT, "sat_reach_int");
      repeat (9) @(negedge clk);
      if (r == 5) sat_lo = 1'b1; else sat_hi = 1'b1;
      @(negedge clk);
      sat_hi = 1'b0; sat_lo = 1'b0;
      check($sformatf("sat%0d_az", r), 32'(state_o), 32'(ST_AZ));
      check($sformatf("sat%0d_range", r), 32'(range_sel_o), 32'(r + 1));
      check($sformatf("sat%0d_no_valid", r), 32'(result_valid_o), 0);
    end
    wait_state(ST_INT, "sat7_reach_int");
    repeat (9) @(negedge clk);
    sat_hi = 1'b1;
    @(negedge clk);
    sat_hi = 1'b0;
    check("sat7_done", 32'(state_o), 32'(ST_DONE));
    wait_valid("sat7_valid");
    check("sat7_word", result_o, 32'h4E05_0000);
    mode_sel = 2'b01;
    accept();
    check("sat7_hold", 32'(state_o), 32'(ST_HOLD));
    mode_sel = 2'b00;
    @(negedge clk);
    check("final_idle", 32'(state_o), 32'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_slope_ctrl.md
Name: dual_slope_ctrl

Overview:
Measurement sequencer for the voltmeter. It consumes the sanitized comparator, saturation and reference-OK flags and drives the analog front-end controls (afe_sel, range_sel, afe_reset, ref_sign) through the auto-zero, integrate and de-integrate phases of a dual-slope conversion. It packs each conversion into a 32-bit result word and presents it on a valid/ready handshake to the SPI transmit path in digital_top.

Parameters:
T_AZ, 64, auto-zero/reset phase length in clk_i cycles (>=1)
T_INT, 1000, fixed integrate phase length in clk_i cycles (>=1)
T_DEINT_MAX, 4095, de-integrate count limit; reaching it flags overrange (< 2^16)
UNDER_DIV, 16, underrange threshold is T_DEINT_MAX/UNDER_DIV (integer division)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
comp_i  in  1  sanitized comparator; 1 = integrator output positive
sat_hi_i  in  1  sanitized integrator high saturation
sat_lo_i  in  1  sanitized integrator low saturation
ref_ok_i  in  1  sanitized reference-good flag
mode_sel_i  in  2  00 idle, 01 single, 10 continuous, 11 continuous+autorange
range_i  in  3  manual range, used in modes 01/10
afe_sel_o  out  2  00 short/zero, 01 input, 10 reference, 11 unused (never driven)
range_sel_o  out  3  active range; 0 = most sensitive
afe_reset_o  out  1  integrator reset switch
ref_sign_o  out  1  reference polarity for de-integrate; 1 = negative ref
result_o  out  32  result word
result_valid_o  out  1  result available
result_ready_i  in  1  consumer accepts result
busy_o  out  1  high in any state except IDLE and HOLD
state_o  out  4  FSM state encoding, debug only

Behaviour:
- All outputs registered. Reset values: afe_sel_o=00, range_sel_o=7, afe_reset_o=1, ref_sign_o=0, result_o=0, result_valid_o=0, busy_o=0, state_o=IDLE. Sequence counter=0, autorange range register=7.
- States: IDLE, AZ, INT, SIGN, DEINT, DONE, WAIT_ACK, HOLD.
- IDLE: afe_sel=00, afe_reset=1. Moves to AZ when mode_sel_i!=00 and ref_ok_i=1. On entry to AZ, range_sel_o loads range_i (modes 01/10) or the autorange register (mode 11).
- AZ: afe_sel=00, afe_reset=1 for exactly T_AZ cycles, then INT.
- INT: afe_sel=01, afe_reset=0 for exactly T_INT cycles, then SIGN.
  - sat_hi_i|sat_lo_i in any INT cycle aborts immediately.
  - On abort in mode 11 with range<7: range register +1, go to AZ, no result emitted.
  - On abort otherwise: go to DONE with sat=1, count=0.
- SIGN (1 cycle): afe_sel=00, polarity P<=comp_i, ref_sign_o<=comp_i.
- DEINT: afe_sel=10. Counter starts at 0 on entry. In any cycle where comp_i!=P, go to DONE with count=counter; otherwise counter+1.
  - If the counter reaches T_DEINT_MAX, go to DONE with count=T_DEINT_MAX and ovr=1.
  - A flip in the first DEINT cycle gives count=0.
- DONE (1 cycle): register the result word. result_valid_o=1 from the next cycle.
  - Result word: [31]=ovr, [30]=sat, [29]=ref_err, [28]=P, [27:25]=range_sel_o, [24]=0, [23:16]=sequence counter, [15:0]=count.
  - In mode 11, if ovr=0, sat=0, count<T_DEINT_MAX/UNDER_DIV and range>0, the range register is decremented for the next conversion.
- WAIT_ACK: afe_sel=00, afe_reset=1. result_o held stable while valid.
  - On result_valid_o & result_ready_i, valid drops next cycle and the sequence counter increments (8-bit, 255 wraps to 0).
  - After acceptance: mode 01 goes to HOLD; modes 10/11 go to AZ; mode 00 goes to IDLE.
  - No new conversion starts while a result is pending, so results are never overwritten.
- HOLD: afe_reset=1. Returns to IDLE when mode_sel_i==00.
- ref_ok_i=0 in AZ/INT/SIGN/DEINT: go to DONE with ref_err=1, count=0.
- mode_sel_i==00 in AZ/INT/SIGN/DEINT: go to IDLE next cycle, no result. A pending result in WAIT_ACK is still delivered.
- Any other mode_sel_i change mid-conversion takes effect at the next AZ entry.
- rst_i mid-operation: all state and outputs return to reset values next edge; any pending result is discarded.

Test Plan:
- Mode 01, range_i=2, comp_i=1 through SIGN, model flips comp_i after 300 DEINT cycles -> result count=300, P=1, ref_sign_o=1, range=2, seq=0, flags 0, valid held until ready; then HOLD.
- Mode 10, comp_i never flips -> count=4095, ovr=1. Hold ready=0 for 50 cycles -> result_o stable and no AZ entry until accept; next result seq=1.
- Mode 11 from reset, count=100 (<255) -> range_sel=7 in result; next conversion on range 6.
- Mode 11 at range 3, sat_hi_i pulse in INT cycle 10 -> AZ restart on range 4, no valid.
- Mode 11 at range 7, saturation -> result with sat=1 and range=7.
- ref_ok_i dropped during DEINT -> result with ref_err=1, count=0.
- mode_sel_i->00 mid-INT -> IDLE next cycle, no valid.
- rst_i mid-DEINT -> all outputs at reset values.
